// File: rtl/branch_pred_ctrl_if.sv
// Fetch, predictor-table and EX-resolve signal bundle for branch_pred_ctrl.
// master = the controller, slave = the surrounding pipeline and table.
interface branch_pred_ctrl_if #(
    parameter int addr_width = 8
);
    logic                  fetch_valid;
    logic                  fetch_is_branch;
    logic [31:0]           fetch_pc;
    logic                  fetch_accept;
    logic                  q_full;
    logic [addr_width-1:0] predictor_raddr;
    logic                  predictor_rd_data;
    logic                  pred_valid;
    logic                  pred_taken;
    logic                  ex_resolve;
    logic                  ex_taken;
    logic [31:0]           ex_target_pc;
    logic [31:0]           ex_fallthru_pc;
    logic                  flush;
    logic [addr_width-1:0] predictor_waddr;
    logic                  predictor_wen;
    logic                  branch_taken_ex;
    logic                  mispredict;
    logic [31:0]           redirect_pc;
    logic                  resolve_err;

    modport master (
        input  fetch_valid, fetch_is_branch, fetch_pc,
        input  predictor_rd_data,
        input  ex_resolve, ex_taken, ex_target_pc, ex_fallthru_pc,
        input  flush,
        output fetch_accept, q_full, predictor_raddr,
        output pred_valid, pred_taken,
        output predictor_waddr, predictor_wen, branch_taken_ex,
        output mispredict, redirect_pc, resolve_err
    );

    modport slave (
        output fetch_valid, fetch_is_branch, fetch_pc,
        output predictor_rd_data,
        output ex_resolve, ex_taken, ex_target_pc, ex_fallthru_pc,
        output flush,
        input  fetch_accept, q_full, predictor_raddr,
        input  pred_valid, pred_taken,
        input  predictor_waddr, predictor_wen, branch_taken_ex,
        input  mispredict, redirect_pc, resolve_err
    );
endinterface

// File: rtl/branch_pred_ctrl.sv
// Branch predictor lookup/update controller: looks up predictions at fetch,
// tracks in-flight branches in order and updates the table at EX resolve.
module branch_pred_ctrl #(
    parameter int entry_num  = 256,
    parameter int addr_width = $clog2(entry_num),
    parameter int q_depth    = 4
) (
    input logic                cpu_clk,
    input logic                cpu_rstn,
    branch_pred_ctrl_if.master bp
);
    localparam int CW = $clog2(q_depth + 1);
    localparam int PW = $clog2(q_depth);

    typedef struct packed {
        logic [addr_width-1:0] idx;
        logic                  pred;
    } ent_t;

    ent_t                  q_mem_q [q_depth];
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         rd_q, rd_d;
    logic [PW-1:0]         wr_q, wr_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [addr_width-1:0] pend_idx_q, pend_idx_d;
    logic                  wen_q, wen_d;
    logic                  mis_q, mis_d;
    logic                  taken_q, taken_d;
    logic                  err_q, err_d;
    logic [addr_width-1:0] waddr_q, waddr_d;
    logic [31:0]           redir_q, redir_d;
    logic                  full;
    logic                  accept;
    logic                  push;
    logic                  pop;
    ent_t                  pend_ent;
    ent_t                  head;
    logic                  unused_pc;

    assign unused_pc = ^{bp.fetch_pc[31:addr_width+2], bp.fetch_pc[1:0]};

    // A pending lookup always owns a slot, so its push can never overflow.
    assign full = ({1'b0, cnt_q} + {{CW{1'b0}}, pend_vld_q})
                  >= (CW+1)'(q_depth);
    assign accept = bp.fetch_valid & bp.fetch_is_branch & ~full;

    assign pend_ent.idx  = pend_idx_q;
    assign pend_ent.pred = bp.predictor_rd_data;
    assign head = (cnt_q != '0) ? q_mem_q[rd_q] : pend_ent;

    assign bp.fetch_accept    = accept;
    assign bp.q_full          = full;
    assign bp.predictor_raddr = bp.fetch_pc[addr_width+1:2];
    assign bp.pred_valid      = pend_vld_q;
    assign bp.pred_taken      = pend_vld_q & bp.predictor_rd_data;
    assign bp.predictor_waddr = waddr_q;
    assign bp.predictor_wen   = wen_q;
    assign bp.branch_taken_ex = taken_q;
    assign bp.mispredict      = mis_q;
    assign bp.redirect_pc     = redir_q;
    assign bp.resolve_err     = err_q;

    always_comb begin
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        pend_vld_d = accept;
        pend_idx_d = accept ? bp.predictor_raddr : pend_idx_q;
        wen_d      = 1'b0;
        mis_d      = 1'b0;
        waddr_d    = waddr_q;
        taken_d    = taken_q;
        redir_d    = redir_q;
        err_d      = err_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (bp.flush) begin
            cnt_d      = '0;
            rd_d       = '0;
            wr_d       = '0;
            pend_vld_d = 1'b0;
        end else begin
            push = pend_vld_q;
            if (bp.ex_resolve) begin
                if (cnt_q != '0 || pend_vld_q) begin
                    wen_d   = 1'b1;
                    waddr_d = head.idx;
                    taken_d = bp.ex_taken;
                    mis_d   = head.pred != bp.ex_taken;
                    redir_d = bp.ex_taken ? bp.ex_target_pc
                                          : bp.ex_fallthru_pc;
                    // Empty queue: the pending entry is consumed directly.
                    if (cnt_q == '0) push = 1'b0;
                    else             pop  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            if (mis_d) begin
                push  = 1'b0;
                pop   = 1'b0;
                cnt_d = '0;
                rd_d  = wr_q;
            end else begin
                cnt_d = cnt_q + CW'(push) - CW'(pop);
                rd_d  = rd_q + PW'(pop);
                wr_d  = wr_q + PW'(push);
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (push) q_mem_q[wr_q] <= pend_ent;
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
            wen_q      <= 1'b0;
            mis_q      <= 1'b0;
            taken_q    <= 1'b0;
            err_q      <= 1'b0;
            waddr_q    <= '0;
            redir_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
            wen_q      <= wen_d;
            mis_q      <= mis_d;
            taken_q    <= taken_d;
            err_q      <= err_d;
            waddr_q    <= waddr_d;
            redir_q    <= redir_d;
        end
    end
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl: lookup vectors, directed
// corner sequences and random traffic against a queue-based model.
module tb_branch_pred_ctrl;
    localparam int AW = 8;
    localparam int QD = 4;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic          pred;
    } ent_t;

    typedef struct {
        logic          fv;
        logic          fb;
        logic [31:0]   pc;
        logic          acc;
        logic [AW-1:0] raddr;
    } vec_t;

    logic cpu_clk  = 1'b0;
    logic cpu_rstn = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    ent_t          mq[$];
    bit            m_pend;
    logic [AW-1:0] m_pidx;
    logic          e_wen, e_mis, e_taken, e_err;
    logic [AW-1:0] e_waddr;
    logic [31:0]   e_redir;

    branch_pred_ctrl_if #(.addr_width(AW)) bp ();

    branch_pred_ctrl #(
        .entry_num (256),
        .q_depth   (QD)
    ) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .bp       (bp)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic idle();
        bp.fetch_valid       = 1'b0;
        bp.fetch_is_branch   = 1'b0;
        bp.fetch_pc          = '0;
        bp.predictor_rd_data = 1'b0;
        bp.ex_resolve        = 1'b0;
        bp.ex_taken          = 1'b0;
        bp.ex_target_pc      = '0;
        bp.ex_fallthru_pc    = '0;
        bp.flush             = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend  = 0;
        m_pidx  = '0;
        e_wen   = 1'b0;
        e_mis   = 1'b0;
        e_taken = 1'b0;
        e_err   = 1'b0;
        e_waddr = '0;
        e_redir = '0;
    endtask

    task automatic do_reset();
        cpu_rstn = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge cpu_clk);
        cpu_rstn = 1'b1;
    endtask

    task automatic fetch(logic [31:0] pc, logic rd);
        idle();
        bp.fetch_valid       = 1'b1;
        bp.fetch_is_branch   = 1'b1;
        bp.fetch_pc          = pc;
        bp.predictor_rd_data = rd;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle();
        bit   ef, ea, hv, hp;
        ent_t h, pe;
        #1;
        ef = (mq.size() + int'(m_pend)) >= QD;
        ea = bp.fetch_valid & bp.fetch_is_branch & !ef;
        chk("q_full", bp.q_full, ef);
        chk("fetch_accept", bp.fetch_accept, ea);
        chk("raddr", bp.predictor_raddr, bp.fetch_pc[AW+1:2]);
        chk("pred_valid", bp.pred_valid, m_pend);
        chk("pred_taken", bp.pred_taken, m_pend & bp.predictor_rd_data);
        chk("wen", bp.predictor_wen, e_wen);
        chk("mispredict", bp.mispredict, e_mis);
        chk("resolve_err", bp.resolve_err, e_err);
        if (e_wen) begin
            chk("waddr", bp.predictor_waddr, e_waddr);
            chk("taken_ex", bp.branch_taken_ex, e_taken);
        end
        if (e_mis) chk("redirect", bp.redirect_pc, e_redir);
        e_wen = 1'b0;
        e_mis = 1'b0;
        if (bp.flush) begin
            mq.delete();
            m_pend = 0;
        end else begin
            pe = '{m_pidx, bp.predictor_rd_data};
            hp = m_pend;
            hv = 0;
            if (bp.ex_resolve) begin
                if (mq.size() > 0) begin
                    h  = mq.pop_front();
                    hv = 1;
                end else if (m_pend) begin
                    h  = pe;
                    hv = 1;
                    hp = 0;
                end else begin
                    e_err = 1'b1;
                end
                if (hv) begin
                    e_wen   = 1'b1;
                    e_waddr = h.idx;
                    e_taken = bp.ex_taken;
                    e_mis   = h.pred != bp.ex_taken;
                    e_redir = bp.ex_taken ? bp.ex_target_pc
                                          : bp.ex_fallthru_pc;
                    if (e_mis) begin
                        mq.delete();
                        hp = 0;
                    end
                end
            end
            if (hp) mq.push_back(pe);
            m_pend = ea;
            m_pidx = bp.fetch_pc[AW+1:2];
        end
        @(posedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    initial begin
        vec_t vt[6];
        logic [31:0] wpc;
        vt[0] = '{1'b1, 1'b1, 32'h0000_0100, 1'b1, 8'h40};
        vt[1] = '{1'b1, 1'b0, 32'h0000_0104, 1'b0, 8'h41};
        vt[2] = '{1'b0, 1'b1, 32'h0000_03FC, 1'b0, 8'hFF};
        vt[3] = '{1'b1, 1'b1, 32'h0000_0400, 1'b1, 8'h00};
        vt[4] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 8'hFF};
        vt[5] = '{1'b0, 1'b0, 32'h0000_0ABC, 1'b0, 8'hAF};

        idle();
        model_reset();
        #2;
        chk("rst_pred_valid", bp.pred_valid, 0);
        chk("rst_pred_taken", bp.pred_taken, 0);
        chk("rst_wen", bp.predictor_wen, 0);
        chk("rst_waddr", bp.predictor_waddr, 0);
        chk("rst_mis", bp.mispredict, 0);
        chk("rst_redirect", bp.redirect_pc, 0);
        chk("rst_err", bp.resolve_err, 0);
        chk("rst_q_full", bp.q_full, 0);

        // Combinational lookup vectors, held in reset so no state moves.
        foreach (vt[i]) begin
            bp.fetch_valid     = vt[i].fv;
            bp.fetch_is_branch = vt[i].fb;
            bp.fetch_pc        = vt[i].pc;
            #1;
            chk("vec_accept", bp.fetch_accept, vt[i].acc);
            chk("vec_raddr", bp.predictor_raddr, vt[i].raddr);
        end

        // Predict/update hit
        do_reset();
        fetch(32'h100, 1'b0); cycle();
        idle(); bp.predictor_rd_data = 1'b1;
        #1;
        chk("hit_pred_valid", bp.pred_valid, 1);
        chk("hit_pred_taken", bp.pred_taken, 1);
        cycle();
        idle(); bp.ex_resolve = 1'b1; bp.ex_taken = 1'b1;
        bp.ex_target_pc = 32'h300; cycle();
        idle();
        chk("hit_waddr", bp.predictor_waddr, 8'h40);
        chk("hit_wen", bp.predictor_wen, 1);
        chk("hit_taken", bp.branch_taken_ex, 1);
        chk("hit_mis", bp.mispredict, 0);
        cycle();
        chk("hit_wen_pulse", bp.predictor_wen, 0);

        // Mispredict squash with 3 queued (preds 0,1,1)
        do_reset();
        fetch(32'h10, 1'b0); cycle();
        fetch(32'h14, 1'b0); cycle();
        fetch(32'h18, 1'b1); cycle();
        idle(); bp.predictor_rd_data = 1'b1; cycle();
        idle(); bp.ex_resolve = 1'b1; bp.ex_taken = 1'b1;
        bp.ex_target_pc = 32'h200; bp.ex_fallthru_pc = 32'h14; cycle();
        idle();
        chk("sq_mis", bp.mispredict, 1);
        chk("sq_redirect", bp.redirect_pc, 32'h200);
        chk("sq_waddr", bp.predictor_waddr, 8'h04);
        bp.ex_resolve = 1'b1; cycle();
        idle();
        chk("sq_err", bp.resolve_err, 1);
        chk("sq_no_wen", bp.predictor_wen, 0);
        cycle();

        // Full
        do_reset();
        for (int k = 0; k < 4; k++) begin
            fetch(32'h400 + 32'(4 * k), 1'b0);
            cycle();
        end
        fetch(32'h410, 1'b0);
        #1;
        chk("full_q_full", bp.q_full, 1);
        chk("full_blocked", bp.fetch_accept, 0);
        bp.ex_resolve = 1'b1; bp.ex_taken = 1'b0; cycle();
        fetch(32'h410, 1'b0);
        #1;
        chk("full_drop", bp.q_full, 0);
        chk("full_reaccept", bp.fetch_accept, 1);
        cycle();

        // Wrap-around: back-to-back push/pop, index crosses 0xFF
        do_reset();
        for (int c = 0; c < 13; c++) begin
            idle();
            if (c < 10) begin
                wpc = 32'h13F0 + 32'(4 * c);
                fetch(wpc, 1'b0);
            end
            if (c >= 2 && c <= 11) bp.ex_resolve = 1'b1;
            if (c >= 3) begin
                #1;
                chk("wrap_wen", bp.predictor_wen, 1);
                chk("wrap_waddr", bp.predictor_waddr, 8'(8'hFC + (c - 3)));
            end
            cycle();
        end

        // Flush overrides a same-cycle resolve
        do_reset();
        fetch(32'h40, 1'b0); cycle();
        fetch(32'h44, 1'b0); cycle();
        idle(); cycle();
        idle(); bp.flush = 1'b1; bp.ex_resolve = 1'b1; bp.ex_taken = 1'b1;
        cycle();
        idle();
        chk("fl_wen", bp.predictor_wen, 0);
        chk("fl_mis", bp.mispredict, 0);
        bp.ex_resolve = 1'b1; cycle();
        idle();
        chk("fl_empty_err", bp.resolve_err, 1);
        cycle();

        // Async reset mid-operation
        do_reset();
        fetch(32'h20, 1'b0); cycle();
        fetch(32'h24, 1'b1); cycle();
        fetch(32'h28, 1'b0); cycle();
        fetch(32'h2C, 1'b1);
        bp.ex_resolve = 1'b1; bp.ex_taken = 1'b1; cycle();
        idle(); bp.predictor_rd_data = 1'b1;
        #1;
        chk("ar_pre_pv", bp.pred_valid, 1);
        chk("ar_pre_wen", bp.predictor_wen, 1);
        cpu_rstn = 1'b0;
        #1;
        chk("ar_pred_valid", bp.pred_valid, 0);
        chk("ar_pred_taken", bp.pred_taken, 0);
        chk("ar_wen", bp.predictor_wen, 0);
        chk("ar_waddr", bp.predictor_waddr, 0);
        chk("ar_taken", bp.branch_taken_ex, 0);
        chk("ar_mis", bp.mispredict, 0);
        chk("ar_redirect", bp.redirect_pc, 0);
        chk("ar_err", bp.resolve_err, 0);
        do_reset();
        idle(); cycle();
        idle(); bp.ex_resolve = 1'b1; cycle();
        idle();
        chk("ar_post_err", bp.resolve_err, 1);
        chk("ar_post_wen", bp.predictor_wen, 0);
        cycle();

        // Random traffic against the model
        for (int s = 0; s < 4; s++) begin
            do_reset();
            for (int n = 0; n < 500; n++) begin
                bp.fetch_valid       = ($urandom_range(1) == 1);
                bp.fetch_is_branch   = ($urandom_range(9) < 7);
                bp.fetch_pc          = $urandom;
                bp.predictor_rd_data = $urandom_range(1) == 1;
                bp.ex_resolve        = ($urandom_range(9) < 4);
                bp.ex_taken          = $urandom_range(1) == 1;
                bp.ex_target_pc      = $urandom;
                bp.ex_fallthru_pc    = $urandom;
                bp.flush             = ($urandom_range(99) < 3);
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_pred_ctrl.md
# branch_pred_ctrl

Branch-prediction lookup/update controller: the initiator side of the 1-bit-output branch predictor table. It drives the table's read address at fetch and captures the returned prediction. It tracks every in-flight predicted branch in an ordered queue. At EX resolution it drives the table's write port (`predictor_waddr`/`predictor_wen`/`branch_taken_ex`) and raises a mispredict redirect to fetch.

## Interface
- `entry_num`, 256, number of predictor entries
- `addr_width`, `$clog2(entry_num)`, predictor index width
- `q_depth`, 4, max in-flight unresolved branches (power of 2, ≥2)

Ports:
- `cpu_clk`  in  1  clock
- `cpu_rstn`  in  1  reset: cpu_rstn, asynchronous, active-low; clock cpu_clk
- `fetch_valid`  in  1  fetch slot valid this cycle
- `fetch_is_branch`  in  1  fetched instruction is a conditional branch
- `fetch_pc`  in  32  PC of fetched instruction
- `fetch_accept`  out  1  branch lookup accepted (= `fetch_valid & fetch_is_branch & !q_full`)
- `q_full`  out  1  no room for another branch; fetch must stall branches
- `predictor_raddr`  out  addr_width  `fetch_pc[addr_width+1:2]`, combinational
- `predictor_rd_data`  in  1  table prediction, valid one cycle after `predictor_raddr`
- `pred_valid`  out  1  prediction for the branch accepted last cycle
- `pred_taken`  out  1  prediction bit (= `predictor_rd_data` when `pred_valid`, else 0)
- `ex_resolve`  in  1  oldest in-flight branch resolves this cycle
- `ex_taken`  in  1  actual outcome
- `ex_target_pc`  in  32  taken target
- `ex_fallthru_pc`  in  32  not-taken PC
- `flush`  in  1  trap/exception flush; discards all in-flight state
- `predictor_waddr`  out  addr_width  update index (registered)
- `predictor_wen`  out  1  update strobe (registered, 1-cycle pulse)
- `branch_taken_ex`  out  1  update outcome (registered)
- `mispredict`  out  1  1-cycle redirect pulse (registered)
- `redirect_pc`  out  32  correct PC, valid with `mispredict`
- `resolve_err`  out  1  sticky: `ex_resolve` seen with empty queue

## Operation
- Lookup stage: on `fetch_accept`, latch index into `pend_idx` and set `pend_vld`.
- Next cycle: `pred_valid`=1, `pred_taken`=`predictor_rd_data`, and push `{pend_idx, predictor_rd_data}` into the queue tail.
- Queue: circular buffer, `q_depth` entries, rd/wr pointers wrap modulo `q_depth`, count width `$clog2(q_depth+1)`.
- `q_full` = (count + `pend_vld`) ≥ `q_depth`. This reserves a slot for the pending push, so a push is never dropped.
- Resolve: on `ex_resolve` with count>0 (count includes the same-cycle push only if the queue was empty and `pend_vld`; in that case the head is the pending entry, bypassed), pop the head. Next cycle:
  - `predictor_wen`=1
  - `predictor_waddr`=head index
  - `branch_taken_ex`=`ex_taken`
  - `mispredict`=(head pred ≠ `ex_taken`)
  - `redirect_pc`=`ex_taken` ? `ex_target_pc` : `ex_fallthru_pc`
- Mispredict squash: in the cycle the mispredict is detected, all remaining queue entries and any same-cycle pending push are discarded (wrong path). Count becomes 0 and the pointers are equalized.
- `ex_resolve` with count 0 and no pending: no update, no mispredict, set `resolve_err` (cleared only by reset).
- `flush`: clears queue, `pend_vld`, and `pred_valid` next cycle. It suppresses any same-cycle `ex_resolve` update and mispredict. `flush` has priority over everything.
- Simultaneous push and pop: both happen; count unchanged.

## Timing
- Reset values: all outputs 0 (`predictor_waddr`=0, `redirect_pc`=0, `resolve_err`=0); queue empty; `q_full`=0.
- Lookup latency: `fetch_accept` at cycle N → `pred_valid`/`pred_taken` at N+1 → entry visible in queue at N+2.
- Update latency: `ex_resolve` at cycle M → `predictor_wen`/`mispredict` at M+1, for exactly one cycle.
- Back-to-back resolves are allowed every cycle.
- `predictor_raddr` is driven every cycle regardless of `fetch_accept`. Table reads are side-effect free.
- Reset mid-operation discards all state asynchronously; no update is emitted after reset release.

## Test plan
- Predict/update hit: `fetch_pc`=0x100 branch, `predictor_rd_data`=1; `ex_resolve` with `ex_taken`=1 → `predictor_waddr`=0x40, `predictor_wen`=1, `branch_taken_ex`=1, `mispredict`=0.
- Mispredict squash: 3 branches queued (predicted 0,1,1). Resolve the first with `ex_taken`=1, `ex_target_pc`=0x200 → `mispredict`=1, `redirect_pc`=0x200, count=0. A following `ex_resolve` sets `resolve_err`=1.
- Full: `q_depth`=4. Accept 4 branches with no resolves → `q_full`=1 after the 4th accept; a 5th branch sees `fetch_accept`=0. Resolve one → `q_full` drops and the next branch is accepted.
- Wrap-around: 10 accept/resolve pairs, interleaved push and pop in the same cycle → FIFO order preserved; `predictor_waddr` sequence matches the accept sequence.
- Flush: `flush` in the same cycle as `ex_resolve` with 2 entries queued → no `predictor_wen` and no `mispredict` next cycle; queue empty.
- Async reset asserted with 2 entries queued and a pending lookup → all outputs 0 immediately; after release, `ex_resolve` sets `resolve_err`.
